// File: rtl/apb_uart_pkg.sv
package apb_uart_pkg;

  localparam logic [4:0] OFF_TRANS_DATA = 5'h00;
  localparam logic [4:0] OFF_RECV_DATA  = 5'h04;
  localparam logic [4:0] OFF_BAUD_CFG   = 5'h08;
  localparam logic [4:0] OFF_FRAME_CFG  = 5'h0C;
  localparam logic [4:0] OFF_PARITY_CFG = 5'h10;
  localparam logic [4:0] OFF_STOP_CFG   = 5'h14;
  localparam logic [4:0] REG_SPAN       = 5'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } apb_state_e;

  typedef enum logic [2:0] {
    ACC_TX,
    ACC_RX,
    ACC_CFG_WR,
    ACC_CFG_RD,
    ACC_ILLEGAL
  } acc_class_e;

endpackage

// File: rtl/apb_uart_addr_decode.sv
module apb_uart_addr_decode
  import apb_uart_pkg::*;
(
  input  logic [4:0] offset_i,
  input  logic       write_i,
  input  logic       in_range_i,
  input  logic       aligned_i,
  output acc_class_e acc_o
);

  always_comb begin
    acc_o = ACC_ILLEGAL;
    if (in_range_i && aligned_i) begin
      case (offset_i)
        OFF_TRANS_DATA: if (write_i)  acc_o = ACC_TX;
        OFF_RECV_DATA:  if (!write_i) acc_o = ACC_RX;
        OFF_BAUD_CFG, OFF_FRAME_CFG, OFF_PARITY_CFG, OFF_STOP_CFG:
          acc_o = write_i ? ACC_CFG_WR : ACC_CFG_RD;
        default: acc_o = ACC_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_slave_fsm.sv
module apb_uart_slave_fsm
  import apb_uart_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = '0,
  parameter int unsigned              TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  tx_req,
  output logic                  rx_req,
  output logic                  cfg_wr_req,
  output logic                  cfg_rd_req,
  output logic [4:0]            req_offset,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_abort,
  input  logic                  uart_ack,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic                  uart_err
);

  localparam int unsigned             CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_WIDTH-1:0]   SPAN     = ADDR_WIDTH'(REG_SPAN);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            off_q, off_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  abort_q, abort_d;
  logic                  tx_q, tx_d;
  logic                  rx_q, rx_d;
  logic                  cwr_q, cwr_d;
  logic                  crd_q, crd_d;

  logic [ADDR_WIDTH-1:0] offset_full;
  logic                  in_range;
  logic                  aligned;
  acc_class_e            acc;

  assign offset_full = PADDR - BASE_ADDR;
  assign in_range    = (offset_full < SPAN);
  assign aligned     = (PADDR[1:0] == 2'b00);

  apb_uart_addr_decode u_decode (
    .offset_i   (offset_full[4:0]),
    .write_i    (PWRITE),
    .in_range_i (in_range),
    .aligned_i  (aligned),
    .acc_o      (acc)
  );

  // Every output register is loaded from the next-state decision, so a
  // registered output is valid in the same cycle as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    abort_d   = 1'b0;
    tx_d      = 1'b0;
    rx_d      = 1'b0;
    cwr_d     = 1'b0;
    crd_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (PSELx && !PENABLE) begin
          off_d   = offset_full[4:0];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          if (acc == ACC_ILLEGAL) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
            tx_d    = (acc == ACC_TX);
            rx_d    = (acc == ACC_RX);
            cwr_d   = (acc == ACC_CFG_WR);
            crd_d   = (acc == ACC_CFG_RD);
          end
        end
      end

      ST_REQ: begin
        if (!PSELx) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (uart_ack) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = uart_err;
          prdata_d  = wr_q ? '0 : uart_rdata;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!PSELx) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (uart_ack) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = uart_err;
            prdata_d  = wr_q ? '0 : uart_rdata;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            abort_d   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      abort_q   <= 1'b0;
      tx_q      <= 1'b0;
      rx_q      <= 1'b0;
      cwr_q     <= 1'b0;
      crd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      abort_q   <= abort_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cwr_q     <= cwr_d;
      crd_q     <= crd_d;
    end
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign tx_req     = tx_q;
  assign rx_req     = rx_q;
  assign cfg_wr_req = cwr_q;
  assign cfg_rd_req = crd_q;
  assign req_offset = off_q;
  assign req_wdata  = wdata_q;
  assign req_abort  = abort_q;

endmodule
